// File: rtl/jtdsp16_rsel_seq_pkg.sv
// Shared definitions for the DSP16 register-read selector: source slot indices,
// the default data width and the sequencer state encoding.
package jtdsp16_rsel_seq_pkg;

  localparam int DSP_DW   = 16;

  localparam int SRC_YAAU = 0;
  localparam int SRC_XAAU = 2;
  localparam int SRC_DAU  = 4;
  localparam int SRC_IF   = 6;
  localparam int SRC_PIO  = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } rsel_state_t;

endpackage

// File: rtl/jtdsp16_rsel_mux.sv
// Combinational NSRC:1 source mux with same-cycle write bypass; out-of-range selects give zero.
// Zero latency, no flow control.
module jtdsp16_rsel_mux
  import jtdsp16_rsel_seq_pkg::*;
#(
  parameter int DW   = DSP_DW,
  parameter int NSRC = 8,
  parameter int SELW = 3
) (
  input  logic [NSRC*DW-1:0] r_in,
  input  logic [SELW-1:0]    sel,
  input  logic               wr_en,
  input  logic [SELW-1:0]    wr_sel,
  input  logic [DW-1:0]      wr_data,
  output logic [DW-1:0]      dat
);

  always_comb begin
    dat = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SELW'(i)) dat = r_in[i*DW +: DW];
    end
    // A write landing on the same edge is newer than the register file output.
    if (wr_en && (wr_sel == sel)) dat = wr_data;
  end

endmodule

// File: rtl/jtdsp16_rsel_seq.sv
// Registered read selector: fast sources return after 1 cen cycle, slow ones after 1+WAITN.
// busy is high during wait states; requests arriving while busy are dropped, not queued.
module jtdsp16_rsel_seq
  import jtdsp16_rsel_seq_pkg::*;
#(
  parameter int          DW        = DSP_DW,
  parameter int          NSRC      = 8,
  parameter int          SELW      = 3,
  parameter logic [31:0] WAIT_MASK = 32'h80,
  parameter int          WAITN     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic [NSRC*DW-1:0] r_in,
  input  logic               rd_req,
  input  logic [SELW-1:0]    rsel,
  input  logic               wr_en,
  input  logic [SELW-1:0]    wr_sel,
  input  logic [DW-1:0]      wr_data,
  output logic [DW-1:0]      rmux,
  output logic               rd_valid,
  output logic               busy
);

  rsel_state_t     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [DW-1:0]   rmux_q, rmux_d;
  logic            rd_valid_q, rd_valid_d;

  logic [SELW-1:0] mux_sel;
  logic [DW-1:0]   mux_dat;
  logic            req_slow;

  // While waiting, the latched index drives the mux so the source is sampled at capture time.
  assign mux_sel  = (state_q == ST_WAIT) ? sel_q : rsel;
  assign req_slow = (32'(rsel) < 32'(NSRC)) && WAIT_MASK[rsel];

  jtdsp16_rsel_mux #(
    .DW   (DW),
    .NSRC (NSRC),
    .SELW (SELW)
  ) u_mux (
    .r_in    (r_in),
    .sel     (mux_sel),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .dat     (mux_dat)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    rmux_d     = rmux_q;
    rd_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          if (req_slow) begin
            sel_d   = rsel;
            cnt_d   = 4'(WAITN - 1);
            state_d = ST_WAIT;
          end else begin
            rmux_d     = mux_dat;
            rd_valid_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          rmux_d     = mux_dat;
          rd_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      rmux_q     <= '0;
      rd_valid_q <= 1'b0;
    end else if (cen) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      rmux_q     <= rmux_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rmux     = rmux_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == ST_WAIT);

endmodule

// File: tb/tb_jtdsp16_rsel_seq.sv
// Directed bench for jtdsp16_rsel_seq: an 8-source instance with a slow PIO slot
// and a 5-source instance for out-of-range selects.
module tb_jtdsp16_rsel_seq;

  logic          clk = 1'b0;
  logic          rst;
  logic          cen;
  logic [127:0]  r_in;
  logic          rd_req;
  logic [2:0]    rsel;
  logic          wr_en;
  logic [2:0]    wr_sel;
  logic [15:0]   wr_data;

  logic [15:0]   a_rmux, b_rmux;
  logic          a_rd_valid, b_rd_valid;
  logic          a_busy, b_busy;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  jtdsp16_rsel_seq #(
    .DW(16), .NSRC(8), .SELW(3), .WAIT_MASK(32'h80), .WAITN(2)
  ) dut_a (
    .clk(clk), .rst(rst), .cen(cen), .r_in(r_in),
    .rd_req(rd_req), .rsel(rsel),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rmux(a_rmux), .rd_valid(a_rd_valid), .busy(a_busy)
  );

  jtdsp16_rsel_seq #(
    .DW(16), .NSRC(5), .SELW(3), .WAIT_MASK(32'h0), .WAITN(2)
  ) dut_b (
    .clk(clk), .rst(rst), .cen(cen), .r_in(r_in[79:0]),
    .rd_req(rd_req), .rsel(rsel),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rmux(b_rmux), .rd_valid(b_rd_valid), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int idx, input logic [15:0] v);
    r_in[idx*16 +: 16] = v;
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; rd_req = 1'b0; rsel = 3'd0;
    wr_en = 1'b0; wr_sel = 3'd0; wr_data = 16'h0;
    r_in = '0;
    for (int i = 0; i < 8; i++) set_slot(i, 16'h1000 + 16'(i));
    set_slot(2, 16'h1234);
    set_slot(4, 16'h4444);
    set_slot(7, 16'hBEEF);
    step(); step();
    chk("reset_rmux", 32'(a_rmux), 32'h0);
    chk("reset_valid", 32'(a_rd_valid), 32'h0);
    chk("reset_busy", 32'(a_busy), 32'h0);
    rst = 1'b0;
    step();

    // Fast read of slot 2
    rd_req = 1'b1; rsel = 3'd2;
    step();
    rd_req = 1'b0;
    chk("fast_rmux", 32'(a_rmux), 32'h1234);
    chk("fast_valid", 32'(a_rd_valid), 32'h1);
    chk("fast_busy", 32'(a_busy), 32'h0);
    step();
    chk("fast_valid_drop", 32'(a_rd_valid), 32'h0);
    chk("fast_rmux_hold", 32'(a_rmux), 32'h1234);

    // Slow read of slot 7 without a change during the wait
    rd_req = 1'b1; rsel = 3'd7;
    step();
    rd_req = 1'b0;
    chk("slow0_busy", 32'(a_busy), 32'h1);
    step();
    chk("slow0_busy2", 32'(a_busy), 32'h1);
    step();
    chk("slow0_rmux", 32'(a_rmux), 32'hBEEF);
    chk("slow0_valid", 32'(a_rd_valid), 32'h1);

    // Slow read of slot 7, source changes mid-wait
    rd_req = 1'b1; rsel = 3'd7;
    step();
    rd_req = 1'b0;
    chk("slow_busy0", 32'(a_busy), 32'h1);
    chk("slow_valid0", 32'(a_rd_valid), 32'h0);
    step();
    chk("slow_busy1", 32'(a_busy), 32'h1);
    chk("slow_valid1", 32'(a_rd_valid), 32'h0);
    set_slot(7, 16'hCAFE);
    step();
    chk("slow_busy_done", 32'(a_busy), 32'h0);
    chk("slow_valid", 32'(a_rd_valid), 32'h1);
    chk("slow_rmux_late", 32'(a_rmux), 32'hCAFE);
    step();
    chk("slow_valid_drop", 32'(a_rd_valid), 32'h0);

    // Bypass: matching write, then back-to-back read with non-matching write
    rd_req = 1'b1; rsel = 3'd4;
    wr_en = 1'b1; wr_sel = 3'd4; wr_data = 16'h00FF;
    step();
    chk("bypass_hit", 32'(a_rmux), 32'h00FF);
    wr_sel = 3'd3;
    step();
    chk("bypass_miss", 32'(a_rmux), 32'h4444);
    chk("b2b_valid", 32'(a_rd_valid), 32'h1);
    rd_req = 1'b0; wr_en = 1'b0;
    step();

    // cen gating during a slow read
    set_slot(7, 16'hBEEF);
    rd_req = 1'b1; rsel = 3'd7;
    step();
    rd_req = 1'b0; cen = 1'b0;
    step();
    chk("cen_busy_a", 32'(a_busy), 32'h1);
    cen = 1'b1;
    step();
    chk("cen_busy_b", 32'(a_busy), 32'h1);
    cen = 1'b0;
    step();
    chk("cen_busy_c", 32'(a_busy), 32'h1);
    chk("cen_valid_c", 32'(a_rd_valid), 32'h0);
    cen = 1'b1;
    step();
    chk("cen_valid", 32'(a_rd_valid), 32'h1);
    chk("cen_rmux", 32'(a_rmux), 32'hBEEF);
    cen = 1'b0;
    step();
    chk("cen_valid_held", 32'(a_rd_valid), 32'h1);
    cen = 1'b1;
    step();
    chk("cen_valid_drop", 32'(a_rd_valid), 32'h0);

    // Request while busy is ignored
    rd_req = 1'b1; rsel = 3'd7;
    step();
    rsel = 3'd2;
    step();
    chk("ign_valid1", 32'(a_rd_valid), 32'h0);
    step();
    rd_req = 1'b0;
    chk("ign_rmux", 32'(a_rmux), 32'hBEEF);
    chk("ign_valid2", 32'(a_rd_valid), 32'h1);
    step();
    chk("ign_valid3", 32'(a_rd_valid), 32'h0);
    chk("ign_busy3", 32'(a_busy), 32'h0);

    // Out-of-range select on the 5-source instance
    rd_req = 1'b1; rsel = 3'd6;
    step();
    chk("oor_rmux", 32'(b_rmux), 32'h0);
    chk("oor_valid", 32'(b_rd_valid), 32'h1);
    chk("oor_busy", 32'(b_busy), 32'h0);
    rsel = 3'd2;
    step();
    chk("inr_rmux", 32'(b_rmux), 32'h1234);
    rd_req = 1'b0;
    step();

    // Reset in the middle of a wait
    rd_req = 1'b1; rsel = 3'd7;
    step();
    rd_req = 1'b0;
    chk("rstw_busy", 32'(a_busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rstw_rmux", 32'(a_rmux), 32'h0);
    chk("rstw_busy0", 32'(a_busy), 32'h0);
    chk("rstw_valid", 32'(a_rd_valid), 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstw_no_valid", 32'(a_rd_valid), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
